clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Runtime-programmable integer clock divider. Generalises the fixed divide-by-5 block to any ratio 2..2^CNT_W-1.
//  Supports a ratio change through a load/ack handshake, an enable, and a period-start tick for data-path logic.
//  Sits in the clock-generation area and drives low-speed peripherals and test clocks from the system clock.
// PARAMETERS
//  CNT_W      8   counter width; maximum ratio is 2^CNT_W-1
//  DIV_RESET  5   ratio loaded at reset; must be >= 2
// PORTS
//  clk        in   1      system clock (single clock; a negedge stage exists only under CLK_DIV_ODD50_EN)
//  rst        in   1      synchronous, active-high reset
//  en         in   1      divider enable
//  div_in     in   CNT_W  requested ratio N
//  div_load   in   1      1-cycle strobe: request ratio div_in
//  div_ack    out  1      1-cycle pulse: pending ratio applied
//  div_err    out  1      1-cycle pulse: rejected request (div_in < 2)
//  div_cur    out  CNT_W  ratio currently in effect
//  tick       out  1      high in the first clk cycle of each output period
//  clk_out    out  1      divided clock
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - cnt=0, div_cur=DIV_RESET, pend=0.
//   - div_ack, div_err, tick and clk_out are 0; the negedge flop also clears while rst is high.
//  Counter: when en=1, cnt counts 0..div_cur-1 and wraps to 0. H = (div_cur+1)>>1.
//  hi_p is a posedge flop, updated with cnt, equal to (cnt_new < H).
//  tick = en & (cnt==0), registered-state-derived, so it is a 1-cycle pulse per period.
//  Even N: clk_out = hi_p. High N/2 cycles, low N/2 cycles.
//  Odd N: see CONFIGURATION.
//  Load handshake:
//   - div_load with div_in >= 2: captured into pend_div, pend=1.
//   - div_load with div_in < 2: div_err pulses the next cycle; pend and div_cur are unchanged.
//   - A further load while pend=1 overwrites pend_div (last wins). There is no extra ack for the overwritten value.
//   - Apply point: the posedge where cnt wraps (div_cur-1 -> 0). At that edge div_cur <= pend_div, pend <= 0, and div_ack pulses.
//   - The new period, its H and its tick all use the new ratio, so there is never a truncated or runt period.
//   - A load and an apply on the same edge: the load in that cycle is captured as a fresh pend after the apply.
//  Enable:
//   - en=0: cnt is held at 0, hi_p=0, clk_out=0, tick=0.
//   - With en=0, a pending ratio applies on the next posedge (div_ack pulses).
//   - en 0->1: the first posedge gives cnt=0, tick=1 and clk_out rising. The first period is full-length.
//  Reset mid-operation: everything returns to reset values next edge; a pending request is discarded with no ack.
//  Output is glitch-free: clk_out is a flop, or an AND of two flops whose edges never coincide.
// CONFIGURATION
//  `define CLK_DIV_ODD50_EN
//   - Defined: a negedge flop sets hi_n <= hi_p, and for odd N, clk_out = hi_p & hi_n.
//     High time is N/2 cycles (50% duty; e.g. N=5 gives 2.5 high / 2.5 low).
//   - Undefined: no negedge logic. For odd N, clk_out = hi_p, high H=(N+1)/2 cycles and low (N-1)/2 cycles.
//   - Even N behaves identically either way.
// STRUCTURE
//  Package clk_div_pkg:
//   - CNT_W default.
//   - typedef div_t = logic [CNT_W-1:0].
//   - Constant DIV_MIN = 2.
//   - Function half_up(div_t n) returning (n+1)>>1.
//  Sub-module: clk_div_odd_stage, the negedge flop plus output AND, instantiated only under CLK_DIV_ODD50_EN.
//  Everything else is in one always block on posedge clk.
// TESTING
//  1. Reset, en=1, N=5 default:
//     - clk_out period 5 cycles; tick every 5th cycle; div_cur=5.
//     - With macro: high 2.5 cycles. Without: high 3, low 2.
//  2. At cnt=1 of a N=5 period, load div_in=4:
//     - The current period finishes at 5 cycles; at the wrap div_ack=1 and div_cur=4.
//     - Next periods: 2 high / 2 low.
//  3. Load div_in=1, then div_in=0:
//     - div_err pulses each time; div_cur stays the same; no div_ack.
//  4. Load 6, then load 8 before the wrap:
//     - Exactly one div_ack; div_cur=8; the period after the wrap is 8 cycles.
//  5. Drop en mid-period:
//     - clk_out=0 and tick=0 next cycle.
//     - Re-raise en: tick on the first edge, then a full-length period.
//  6. Assert rst mid-period with a load pending:
//     - All outputs 0, div_cur=DIV_RESET, no div_ack.
//     - Resumes with N=5 after release.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Contents:
//   CNT_W    default counter width
//   div_t    ratio / counter type
//   DIV_MIN  smallest ratio the divider accepts
//   half_up  high-phase length for a ratio: (n+1)>>1, without overflow
package clk_div_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DIV_MIN = 2;

  typedef logic [CNT_W-1:0] div_t;

  function automatic div_t half_up(input div_t n);
    logic [CNT_W:0] wide;
    wide = ({1'b0, n} + 1'b1) >> 1;
    return wide[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/clk_div_odd_stage.sv
// Negedge extension stage for 50% duty on odd ratios.
// hi_n follows hi_p half a cycle later. For odd ratios the output is
// hi_p & hi_n, which trims half a cycle from the leading edge of the high phase.
// The two flops toggle on opposite clock edges, so the AND cannot glitch.
// Ports:
//   clk      in  system clock (hi_n is captured on its falling edge)
//   rst      in  synchronous active-high reset, sampled on the falling edge
//   hi_p     in  posedge high-phase flop from the divider
//   odd      in  the ratio in effect is odd
//   clk_out  out divided clock
module clk_div_odd_stage (
  input  logic clk,
  input  logic rst,
  input  logic hi_p,
  input  logic odd,
  output logic clk_out
);

  logic hi_n;

  always_ff @(negedge clk) begin
    if (rst) hi_n <= 1'b0;
    else     hi_n <= hi_p;
  end

  assign clk_out = odd ? (hi_p & hi_n) : hi_p;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider (ratio 2 .. 2^CNT_W-1).
// A new ratio is requested with a load strobe. It takes effect only at a
// period boundary, so the output never has a runt period.
// Optional feature: define CLK_DIV_ODD50_EN for 50% duty on odd ratios.
// This adds a negedge stage.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   en        in   divider enable
//   div_in    in   requested ratio
//   div_load  in   1-cycle request strobe for div_in
//   div_ack   out  1-cycle pulse when the pending ratio is applied
//   div_err   out  1-cycle pulse when a request is rejected (div_in < 2)
//   div_cur   out  ratio currently in effect
//   tick      out  high in the first cycle of each output period
//   clk_out   out  divided clock
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W     = clk_div_pkg::CNT_W,
  parameter int unsigned DIV_RESET = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic [CNT_W-1:0] div_cur,
  output logic             tick,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W:0]   half_nxt;
  logic             pend;
  logic             run;
  logic             hi_p;
  logic             wrap;
  logic             period_start;
  logic             apply;
  logic             load_ok;

  // run distinguishes "cnt held at 0 while disabled" from a counting 0.
  // On the first enabled edge, a fresh full period starts instead of advancing the count.
  always_comb begin
    wrap         = run & (cnt == div_cur - 1'b1);
    period_start = en & (~run | wrap);
    apply        = pend & (period_start | ~en);
    div_nxt      = apply ? pend_div : div_cur;
    cnt_nxt      = (period_start | ~en) ? '0 : cnt + 1'b1;
    half_nxt     = ({1'b0, div_nxt} + 1'b1) >> 1;
    load_ok      = div_load & (div_in >= CNT_W'(DIV_MIN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      div_cur  <= CNT_W'(DIV_RESET);
      pend     <= 1'b0;
      pend_div <= '0;
      run      <= 1'b0;
      hi_p     <= 1'b0;
      tick     <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      run     <= en;
      cnt     <= cnt_nxt;
      div_cur <= div_nxt;
      div_ack <= apply;
      div_err <= div_load & ~load_ok;
      // The new period's high phase and tick use the ratio applied on this same edge.
      hi_p    <= en & ({1'b0, cnt_nxt} < half_nxt);
      tick    <= en & (cnt_nxt == '0);
      // A load on the apply edge wins over clearing pend.
      if (load_ok) begin
        pend     <= 1'b1;
        pend_div <= div_in;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_ODD50_EN
  clk_div_odd_stage u_odd_stage (
    .clk     (clk),
    .rst     (rst),
    .hi_p    (hi_p),
    .odd     (div_cur[0]),
    .clk_out (clk_out)
  );
`else
  assign clk_out = hi_p;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       div_ack;
  logic       div_err;
  logic [7:0] div_cur;
  logic       tick;
  logic       clk_out;

  clk_div_prog #(.CNT_W(8), .DIV_RESET(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .div_cur  (div_cur),
    .tick     (tick),
    .clk_out  (clk_out)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: the period is tracked by its start time.
  // A pending request is applied at the next period boundary.
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned ratio = 5;
  int unsigned pend_val = 0;
  bit          pend = 0;
  bit          running = 0;
  bit          hi = 0;
  bit          prev_hi = 0;
  bit          e_tick = 0, e_ack = 0, e_err = 0, e_clk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit l, input logic [7:0] d);
    bit boundary;
    rst = r; en = e; div_load = l; div_in = d;
    @(posedge clk);
    cyc++;
    prev_hi = hi;
    if (r) begin
      running = 0; ratio = 5; pend = 0;
      e_ack = 0; e_err = 0; e_tick = 0; hi = 0; prev_hi = 0;
    end else begin
      e_err    = l && (d < 2);
      boundary = e && (!running || (cyc - start_cyc) >= ratio);
      e_ack    = pend && (boundary || !e);
      if (e_ack) begin ratio = pend_val; pend = 0; end
      if (l && d >= 2) begin pend = 1; pend_val = d; end
      if (e) begin
        if (boundary) start_cyc = cyc;
        running = 1;
      end else begin
        running = 0;
      end
      hi     = e && ((cyc - start_cyc) < (ratio + 1) / 2);
      e_tick = e && (cyc == start_cyc);
    end
`ifdef CLK_DIV_ODD50_EN
    e_clk = (ratio % 2 == 1) ? (hi && prev_hi) : hi;
`else
    e_clk = hi;
`endif
    #1;
    check("tick", tick, e_tick);
    check("clk_out", clk_out, e_clk);
    check("div_ack", div_ack, e_ack);
    check("div_err", div_err, e_err);
    check("div_cur", div_cur, ratio);
  endtask

  // Run until a tick is seen, with a bounded wait.
  task automatic run_to_tick(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(0, 1, 0, 0);
      seen = tick;
    end
    check(tag, seen, 1);
  endtask

  int unsigned n_tick, n_ack, n_err;

  initial begin
    rst = 1; en = 0; div_load = 0; div_in = '0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_div_cur", div_cur, 5);
    check("rst_clk_out", clk_out, 0);

    // 1. Default N=5: three ticks in 15 edges, first on the first enabled edge
    n_tick = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, 0);
      if (i == 0) check("t1_first_tick", tick, 1);
      n_tick += tick;
    end
    check("t1_ticks", n_tick, 3);

    // 2. Load 4 while cnt=1
    run_to_tick("t2_wait_tick");
    step(0, 1, 0, 0);
    step(0, 1, 1, 8'd4);
    n_ack = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0);
      n_ack += div_ack;
    end
    check("t2_acks", n_ack, 1);
    check("t2_div_cur", div_cur, 4);

    // 3. Rejected ratios 1 and 0
    step(0, 1, 1, 8'd1);
    n_err = div_err;
    step(0, 1, 1, 8'd0);
    n_err += div_err;
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0);
      n_err += div_err;
      n_ack += div_ack;
    end
    check("t3_errs", n_err, 2);
    check("t3_acks", n_ack, 0);
    check("t3_div_cur", div_cur, 4);

    // 4. Load 6 then 8 before the wrap: last request wins, one ack
    run_to_tick("t4_wait_tick");
    step(0, 1, 1, 8'd6);
    step(0, 1, 1, 8'd8);
    n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0);
      n_ack += div_ack;
    end
    check("t4_acks", n_ack, 1);
    check("t4_div_cur", div_cur, 8);

    // 5. Drop en mid-period, then re-raise it
    run_to_tick("t5_wait_tick");
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("t5_off_clk", clk_out, 0);
    check("t5_off_tick", tick, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("t5_on_tick", tick, 1);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0);

    // 6. Reset with a request pending: the request is discarded
    run_to_tick("t6_wait_tick");
    step(0, 1, 1, 8'd3);
    step(1, 1, 0, 0);
    check("t6_div_cur", div_cur, 5);
    check("t6_clk_out", clk_out, 0);
    n_ack = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0);
      n_ack += div_ack;
    end
    check("t6_acks", n_ack, 0);
    check("t6_div_cur_after", div_cur, 5);

    // Randomized traffic compared against the model every cycle
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 5) == 0,
           8'($urandom_range(0, 12)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
